adder_rr_scheduler: RTL

//  Shares one combinational 8-bit ripple adder (a + b + c_in -> sum, c_out)

---
 rtl/adder_rr_scheduler_if.sv | 35 +++
 rtl/adder_rr_scheduler.sv | 126 ++++++++++++
 2 files changed

// File: rtl/adder_rr_scheduler_if.sv
// +-----------------------------------------------------------------------------+
// | adder_rr_scheduler_if : requester/consumer handshake bundle for the shared   |
// | adder scheduler.                          Rev 1.0                            |
// +-----------------------------------------------------------------------------+
`default_nettype none

interface adder_rr_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       req_c_in;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [IDW-1:0]           rsp_id;
  logic [WIDTH-1:0]         rsp_sum;
  logic                     rsp_c_out;

  modport master (
    output req_valid, req_a, req_b, req_c_in, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_c_out
  );

  modport slave (
    input  req_valid, req_a, req_b, req_c_in, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_c_out
  );
endinterface

`default_nettype wire

// File: rtl/adder_rr_scheduler.sv
// +-----------------------------------------------------------------------------+
// | adder_rr_scheduler : round-robin sharing of one ripple adder, 1-deep result  |
// | slot. Optional per-requester grant counters: ADDER_RR_SCHED_STATS_EN. Rev 1.0|
// +-----------------------------------------------------------------------------+
`default_nettype none

module adder_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  adder_rr_scheduler_if.slave  bus
`ifdef ADDER_RR_SCHED_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0] grant_cnt
`endif
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDW:0]   C_NUM_REQ_W = (IDW+1)'(NUM_REQ);
  localparam logic [IDW-1:0] C_LAST_ID   = IDW'(NUM_REQ - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_e;

  state_e             state_q;
  logic [IDW-1:0]     rr_ptr_q;
  logic               rsp_valid_q;
  logic [IDW-1:0]     rsp_id_q;
  logic [WIDTH-1:0]   rsp_sum_q;
  logic               rsp_c_out_q;

  logic [IDW-1:0]     grant;
  logic               any_valid;
  logic               can_accept;
  logic               accept;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic               op_c;
  logic [WIDTH-1:0]   add_sum;
  logic               add_c_out;
  logic [IDW-1:0]     rr_ptr_d;

  // Scan from highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    logic [IDW:0] idx;
    grant = '0;
    idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (idx >= C_NUM_REQ_W) begin
        idx = idx - C_NUM_REQ_W;
      end
      if (bus.req_valid[idx[IDW-1:0]]) begin
        grant = idx[IDW-1:0];
      end
    end
  end

  assign any_valid  = |bus.req_valid;
  assign can_accept = ~rst & ((state_q == S_IDLE) | ((state_q == S_HOLD) & bus.rsp_ready));
  assign accept     = can_accept & any_valid;
  assign bus.req_ready = accept ? (NUM_REQ'(1) << grant) : '0;

  assign op_a = bus.req_a[grant*WIDTH +: WIDTH];
  assign op_b = bus.req_b[grant*WIDTH +: WIDTH];
  assign op_c = bus.req_c_in[grant];

  always_comb begin
    logic carry;
    carry   = op_c;
    add_sum = '0;
    for (int i = 0; i < WIDTH; i++) begin
      add_sum[i] = op_a[i] ^ op_b[i] ^ carry;
      carry      = (op_a[i] & op_b[i]) | (carry & (op_a[i] ^ op_b[i]));
    end
    add_c_out = carry;
  end

  assign rr_ptr_d = (grant == C_LAST_ID) ? '0 : grant + IDW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_c_out_q <= 1'b0;
    end else if (accept) begin
      state_q     <= S_HOLD;
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= 1'b1;
      rsp_id_q    <= grant;
      rsp_sum_q   <= add_sum;
      rsp_c_out_q <= add_c_out;
    end else if ((state_q == S_HOLD) && bus.rsp_ready) begin
      state_q     <= S_IDLE;
      rsp_valid_q <= 1'b0;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_c_out = rsp_c_out_q;

`ifdef ADDER_RR_SCHED_STATS_EN
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cnt
    logic [15:0] cnt_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
      end else if (accept && (grant == IDW'(gi)) && (cnt_q != 16'hFFFF)) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
    assign grant_cnt[gi*16 +: 16] = cnt_q;
  end
`endif

endmodule

`default_nettype wire
